// File: rtl/apb_master.sv
// apb_master: APB initiator that turns single-beat requester commands into
// APB transfers and returns a one-cycle response pulse.
// Optional feature macro: APB_MASTER_TIMEOUT_EN adds an ACCESS-phase wait
// limit of TIMEOUT_CYCLES cycles. When it is undefined, the design waits on
// PREADY forever and RSP_TIMEOUT is tied low.
module apb_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic                  CMD_WRITE,
  input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic [DATA_WIDTH-1:0] CMD_WDATA,
  output logic                  RSP_VALID,
  output logic [DATA_WIDTH-1:0] RSP_RDATA,
  output logic                  RSP_ERROR,
  output logic                  RSP_TIMEOUT,
  output logic                  PSELx,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic                    psel_next;
  logic                    penable_next;
  logic                    pwrite_next;
  logic [ADDR_WIDTH-1:0]   paddr_next;
  logic [DATA_WIDTH-1:0]   pwdata_next;
  logic                    rsp_valid_next;
  logic [DATA_WIDTH-1:0]   rsp_rdata_next;
  logic                    rsp_error_next;
  logic                    timeout_hit;

  // The requester may only hand over a command while the bus is idle.
  assign CMD_READY = (state == IDLE) && !PRESET;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_count;
  logic             rsp_timeout_next;

  // The limit is reached on the edge whose stalled cycle brings the count to
  // TIMEOUT_CYCLES; a PREADY in that same cycle takes precedence.
  assign timeout_hit = (state == ACCESS) && !PREADY &&
                       (wait_count == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count consecutive stalled ACCESS cycles, restarting for every new transfer.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wait_count <= '0;
    end else if (state_next == SETUP) begin
      wait_count <= '0;
    end else if ((state == ACCESS) && !PREADY) begin
      wait_count <= wait_count + CNT_W'(1);
    end
  end

  // Timeout flag is registered alongside the rest of the response.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      RSP_TIMEOUT <= 1'b0;
    end else begin
      RSP_TIMEOUT <= rsp_timeout_next;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign RSP_TIMEOUT = 1'b0;
`endif

  // Next-state and next-output decode; bus signals hold unless a phase changes.
  always_comb begin
    state_next     = state;
    psel_next      = PSELx;
    penable_next   = PENABLE;
    pwrite_next    = PWRITE;
    paddr_next     = PADDR;
    pwdata_next    = PWDATA;
    rsp_valid_next = 1'b0;
    rsp_rdata_next = RSP_RDATA;
    rsp_error_next = RSP_ERROR;
`ifdef APB_MASTER_TIMEOUT_EN
    rsp_timeout_next = RSP_TIMEOUT;
`endif
    case (state)
      IDLE: begin
        if (CMD_VALID && CMD_READY) begin
          state_next   = SETUP;
          psel_next    = 1'b1;
          penable_next = 1'b0;
          pwrite_next  = CMD_WRITE;
          paddr_next   = CMD_ADDR;
          pwdata_next  = CMD_WDATA;
        end
      end
      SETUP: begin
        state_next   = ACCESS;
        penable_next = 1'b1;
      end
      ACCESS: begin
        if (PREADY) begin
          state_next     = IDLE;
          psel_next      = 1'b0;
          penable_next   = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_rdata_next = PWRITE ? '0 : PRDATA;
          rsp_error_next = PSLVERR;
`ifdef APB_MASTER_TIMEOUT_EN
          rsp_timeout_next = 1'b0;
`endif
        end else if (timeout_hit) begin
          state_next     = IDLE;
          psel_next      = 1'b0;
          penable_next   = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_rdata_next = '0;
          rsp_error_next = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
          rsp_timeout_next = 1'b1;
`endif
        end
      end
      default: begin
        state_next   = IDLE;
        psel_next    = 1'b0;
        penable_next = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any transfer on the same edge.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      PSELx     <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      RSP_VALID <= 1'b0;
      RSP_RDATA <= '0;
      RSP_ERROR <= 1'b0;
    end else begin
      state     <= state_next;
      PSELx     <= psel_next;
      PENABLE   <= penable_next;
      PWRITE    <= pwrite_next;
      PADDR     <= paddr_next;
      PWDATA    <= pwdata_next;
      RSP_VALID <= rsp_valid_next;
      RSP_RDATA <= rsp_rdata_next;
      RSP_ERROR <= rsp_error_next;
    end
  end

endmodule
